// File: rtl/f1_response_checker.sv
// Response checker for the 4-input function f1: accepts vectors over valid/ready, waits SETTLE_CYCLES, samples f1
// and compares it against the EXPECTED truth table. Optional macro F1_CHK_COVERAGE_EN makes completion require every vector.
module f1_response_checker #(
  parameter logic [15:0] EXPECTED      = 16'h0000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vec_valid,
  input  logic [3:0] vec,
  output logic       vec_ready,
  input  logic       f1,
  input  logic       restart,
  output logic [4:0] mismatch_count,
  output logic [4:0] sample_count,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_vec,
  output logic       done,
  output logic       pass
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [4:0] COUNT_MAX   = 5'd16;

  state_t     state_q, state_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [3:0] cur_vec_q, cur_vec_d;
  logic       vec_ready_q, vec_ready_d;
  logic [4:0] mismatch_count_q, mismatch_count_d;
  logic [4:0] sample_count_q, sample_count_d;
  logic       first_fail_valid_q, first_fail_valid_d;
  logic [3:0] first_fail_vec_q, first_fail_vec_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       sample_mismatch;
  logic       complete;
`ifdef F1_CHK_COVERAGE_EN
  logic [15:0] seen_q, seen_d;
`endif

  function automatic logic [4:0] sat_inc(input logic [4:0] x);
    return (x >= COUNT_MAX) ? x : x + 5'd1;
  endfunction

  always_comb begin
    state_d            = state_q;
    settle_cnt_d       = settle_cnt_q;
    cur_vec_d          = cur_vec_q;
    vec_ready_d        = 1'b0;
    mismatch_count_d   = mismatch_count_q;
    sample_count_d     = sample_count_q;
    first_fail_valid_d = first_fail_valid_q;
    first_fail_vec_d   = first_fail_vec_q;
    done_d             = done_q;
    pass_d             = pass_q;
    sample_mismatch    = 1'b0;
    complete           = 1'b0;
`ifdef F1_CHK_COVERAGE_EN
    seen_d             = seen_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (vec_valid && vec_ready_q) begin
          cur_vec_d    = vec;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
        end else begin
          vec_ready_d = 1'b1;
        end
      end
      S_SETTLE: begin
        // Leaving at a count of 1 puts the sample exactly SETTLE_CYCLES+1 edges after acceptance.
        if (settle_cnt_q <= 8'd1) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        sample_mismatch = (f1 != EXPECTED[cur_vec_q]);
        sample_count_d  = sat_inc(sample_count_q);
        if (sample_mismatch) begin
          mismatch_count_d = sat_inc(mismatch_count_q);
          if (!first_fail_valid_q) begin
            first_fail_valid_d = 1'b1;
            first_fail_vec_d   = cur_vec_q;
          end
        end
`ifdef F1_CHK_COVERAGE_EN
        seen_d   = seen_q | (16'h0001 << cur_vec_q);
        complete = &seen_d;
`else
        complete = (sample_count_d == COUNT_MAX);
`endif
        if (complete) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (mismatch_count_d == 5'd0);
        end else begin
          state_d     = S_IDLE;
          vec_ready_d = 1'b1;
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Restart overrides everything, including a handshake in the same cycle.
    if (restart) begin
      state_d            = S_IDLE;
      vec_ready_d        = 1'b1;
      mismatch_count_d   = 5'd0;
      sample_count_d     = 5'd0;
      first_fail_valid_d = 1'b0;
      first_fail_vec_d   = 4'd0;
      done_d             = 1'b0;
      pass_d             = 1'b0;
`ifdef F1_CHK_COVERAGE_EN
      seen_d             = 16'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      settle_cnt_q       <= 8'd0;
      cur_vec_q          <= 4'd0;
      vec_ready_q        <= 1'b0;
      mismatch_count_q   <= 5'd0;
      sample_count_q     <= 5'd0;
      first_fail_valid_q <= 1'b0;
      first_fail_vec_q   <= 4'd0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
`ifdef F1_CHK_COVERAGE_EN
      seen_q             <= 16'd0;
`endif
    end else begin
      state_q            <= state_d;
      settle_cnt_q       <= settle_cnt_d;
      cur_vec_q          <= cur_vec_d;
      vec_ready_q        <= vec_ready_d;
      mismatch_count_q   <= mismatch_count_d;
      sample_count_q     <= sample_count_d;
      first_fail_valid_q <= first_fail_valid_d;
      first_fail_vec_q   <= first_fail_vec_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
`ifdef F1_CHK_COVERAGE_EN
      seen_q             <= seen_d;
`endif
    end
  end

  assign vec_ready        = vec_ready_q;
  assign mismatch_count   = mismatch_count_q;
  assign sample_count     = sample_count_q;
  assign first_fail_valid = first_fail_valid_q;
  assign first_fail_vec   = first_fail_vec_q;
  assign done             = done_q;
  assign pass             = pass_q;

endmodule

// File: tb/tb_f1_response_checker.sv
// Scoreboard bench for f1_response_checker: dut index 0 has SETTLE_CYCLES=0, index 1 has SETTLE_CYCLES=4.
// Coverage-mode expectations are selected with F1_CHK_COVERAGE_EN.
module tb_f1_response_checker;
  localparam logic [15:0] EXP = 16'hA5C3;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       restart [2];
  logic       vec_valid [2];
  logic [3:0] vec [2];
  logic       f1 [2];
  logic       vec_ready [2];
  logic [4:0] mc_o [2];
  logic [4:0] sc_o [2];
  logic       ffv_o [2];
  logic [3:0] ffvec_o [2];
  logic       done_o [2];
  logic       pass_o [2];

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] v;
    logic [4:0] sc;
    logic [4:0] mc;
    logic       ffv;
    logic [3:0] ffvec;
    logic       done;
    logic       pass;
  } exp_t;
  exp_t sb[$];

  logic [4:0]  m_sc, m_mc;
  logic        m_ffv, m_done, m_pass;
  logic [3:0]  m_ffvec;
  logic [15:0] m_seen;

  always #5 clk = ~clk;

  f1_response_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .vec_valid(vec_valid[0]), .vec(vec[0]), .vec_ready(vec_ready[0]),
    .f1(f1[0]), .restart(restart[0]), .mismatch_count(mc_o[0]), .sample_count(sc_o[0]),
    .first_fail_valid(ffv_o[0]), .first_fail_vec(ffvec_o[0]), .done(done_o[0]), .pass(pass_o[0])
  );

  f1_response_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst[1]), .vec_valid(vec_valid[1]), .vec(vec[1]), .vec_ready(vec_ready[1]),
    .f1(f1[1]), .restart(restart[1]), .mismatch_count(mc_o[1]), .sample_count(sc_o[1]),
    .first_fail_valid(ffv_o[1]), .first_fail_vec(ffvec_o[1]), .done(done_o[1]), .pass(pass_o[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sc = 5'd0; m_mc = 5'd0; m_ffv = 1'b0; m_ffvec = 4'd0;
    m_seen = 16'd0; m_done = 1'b0; m_pass = 1'b0;
    sb.delete();
  endtask

  // Predicted register state after the sample of vector v with f1 value fv.
  task automatic model_push(input logic [3:0] v, input logic fv);
    exp_t e;
    logic bad;
    bad = (fv != EXP[v]);
    if (m_sc < 5'd16) m_sc = m_sc + 5'd1;
    if (bad && m_mc < 5'd16) m_mc = m_mc + 5'd1;
    if (bad && !m_ffv) begin
      m_ffv = 1'b1;
      m_ffvec = v;
    end
    m_seen[v] = 1'b1;
`ifdef F1_CHK_COVERAGE_EN
    m_done = (m_seen == 16'hFFFF);
`else
    m_done = (m_sc == 5'd16);
`endif
    m_pass = m_done && (m_mc == 5'd0);
    e.v = v; e.sc = m_sc; e.mc = m_mc; e.ffv = m_ffv; e.ffvec = m_ffvec;
    e.done = m_done; e.pass = m_pass;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int d);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    $display("[TB] dut%0d vec=%h sc=%0d mc=%0d ffv=%0b ffvec=%h done=%0b pass=%0b",
             d, e.v, sc_o[d], mc_o[d], ffv_o[d], ffvec_o[d], done_o[d], pass_o[d]);
    check_eq("sample_count", 32'(sc_o[d]), 32'(e.sc));
    check_eq("mismatch_count", 32'(mc_o[d]), 32'(e.mc));
    check_eq("first_fail_valid", 32'(ffv_o[d]), 32'(e.ffv));
    check_eq("first_fail_vec", 32'(ffvec_o[d]), 32'(e.ffvec));
    check_eq("done", 32'(done_o[d]), 32'(e.done));
    check_eq("pass", 32'(pass_o[d]), 32'(e.pass));
  endtask

  // Drive one vector; f1 is wrong until just after acceptance so a sample taken too early is caught.
  task automatic send(input int d, input logic [3:0] v, input logic inv);
    int guard;
    int s;
    logic fv;
    logic [4:0] prev_sc;
    s = (d == 0) ? 0 : 4;
    fv = EXP[v] ^ inv;
    @(negedge clk);
    vec_valid[d] = 1'b1; vec[d] = v; f1[d] = ~fv;
    guard = 0;
    while (vec_ready[d] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      vec_valid[d] = 1'b0;
      check_eq("ready_timeout", 0, 1);
      return;
    end
    prev_sc = m_sc;
    model_push(v, fv);
    @(posedge clk); #1;
    vec_valid[d] = 1'b0; vec[d] = ~v; f1[d] = fv;
    check_eq("ready_drop", 32'(vec_ready[d]), 0);
    repeat (s) @(posedge clk);
    #1;
    check_eq("pre_sample", 32'(sc_o[d]), 32'(prev_sc));
    @(posedge clk); #1;
    pop_check(d);
  endtask

  task automatic do_restart(input int d);
    @(negedge clk);
    restart[d] = 1'b1;
    @(posedge clk); #1;
    restart[d] = 1'b0;
    model_reset();
    check_eq("rst_sc", 32'(sc_o[d]), 0);
    check_eq("rst_mc", 32'(mc_o[d]), 0);
    check_eq("rst_done", 32'(done_o[d]), 0);
    check_eq("rst_ffv", 32'(ffv_o[d]), 0);
    check_eq("rst_ready", 32'(vec_ready[d]), 1);
  endtask

  task automatic collide(input int d);
    @(negedge clk);
    restart[d] = 1'b1; vec_valid[d] = 1'b1; vec[d] = 4'h3; f1[d] = 1'b0;
    @(posedge clk); #1;
    restart[d] = 1'b0; vec_valid[d] = 1'b0;
    model_reset();
    check_eq("col_ready", 32'(vec_ready[d]), 1);
    check_eq("col_sc", 32'(sc_o[d]), 0);
    check_eq("col_done", 32'(done_o[d]), 0);
    repeat (8) @(posedge clk);
    #1;
    check_eq("col_noaccept", 32'(sc_o[d]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cur;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; restart[i] = 1'b0; vec_valid[i] = 1'b0; vec[i] = 4'd0; f1[i] = 1'b0;
    end
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", 32'(vec_ready[1]), 0);
    check_eq("reset_sc", 32'(sc_o[1]), 0);
    check_eq("reset_mc", 32'(mc_o[1]), 0);
    check_eq("reset_ffv", 32'(ffv_o[1]), 0);
    check_eq("reset_ffvec", 32'(ffvec_o[1]), 0);
    check_eq("reset_done", 32'(done_o[1]), 0);
    check_eq("reset_pass", 32'(pass_o[1]), 0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;
    check_eq("release_ready", 32'(vec_ready[1]), 1);

    // Golden pass
    for (int v = 0; v < 16; v++) send(1, 4'(v), 1'b0);
    check_eq("golden_done", 32'(done_o[1]), 1);
    check_eq("golden_pass", 32'(pass_o[1]), 1);
    check_eq("golden_mc", 32'(mc_o[1]), 0);
    check_eq("golden_sc", 32'(sc_o[1]), 16);
    check_eq("golden_ffv", 32'(ffv_o[1]), 0);

    // Injected faults on vectors 5 and 9
    do_restart(1);
    for (int v = 0; v < 16; v++) send(1, 4'(v), (v == 5 || v == 9));
    check_eq("fault_mc", 32'(mc_o[1]), 2);
    check_eq("fault_ffvec", 32'(ffvec_o[1]), 5);
    check_eq("fault_pass", 32'(pass_o[1]), 0);
    check_eq("fault_done", 32'(done_o[1]), 1);

    // Restart colliding with a handshake, first from DONE, then from IDLE with ready high
    collide(1);
    collide(1);

    // Abort mid-SETTLE after 7 samples, then a full clean run
    for (int v = 0; v < 7; v++) send(1, 4'(v), 1'b0);
    @(negedge clk);
    vec_valid[1] = 1'b1; vec[1] = 4'h7; f1[1] = ~EXP[7];
    @(posedge clk); #1;
    vec_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_ready", 32'(vec_ready[1]), 0);
    check_eq("abort_sc", 32'(sc_o[1]), 0);
    check_eq("abort_mc", 32'(mc_o[1]), 0);
    check_eq("abort_done", 32'(done_o[1]), 0);
    @(negedge clk);
    rst[1] = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_eq("abort_ready_back", 32'(vec_ready[1]), 1);
    for (int v = 0; v < 16; v++) send(1, 4'(v), 1'b0);
    check_eq("rerun_pass", 32'(pass_o[1]), 1);

    // Zero settle: valid held high, ready toggles, f1 sampled in the cycle after acceptance
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    model_reset();
    vec_valid[0] = 1'b1;
    cur = 4'd0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      check_eq("toggle_ready", 32'(vec_ready[0]), 32'((k % 2 == 1) && (k < 33)));
      if (k % 2 == 1 && k >= 3) pop_check(0);
      if (k % 2 == 1 && k <= 31) begin
        cur = 4'((k - 1) / 2);
        vec[0] = cur; f1[0] = ~EXP[cur];
        model_push(cur, EXP[cur]);
      end else if (k % 2 == 0) begin
        vec[0] = ~cur; f1[0] = EXP[cur];
      end
    end
    vec_valid[0] = 1'b0;
    check_eq("zs_done", 32'(done_o[0]), 1);
    check_eq("zs_pass", 32'(pass_o[0]), 1);
    check_eq("zs_sc", 32'(sc_o[0]), 16);

    // Duplicate vector 3, every other vector but 7, then 7
    do_restart(1);
    send(1, 4'h3, 1'b0);
    for (int v = 0; v < 16; v++) begin
      if (v != 7 && !m_done) send(1, 4'(v), 1'b0);
    end
`ifdef F1_CHK_COVERAGE_EN
    check_eq("cov_not_done", 32'(done_o[1]), 0);
    check_eq("cov_sat_sc", 32'(sc_o[1]), 16);
    send(1, 4'h7, 1'b0);
`endif
    check_eq("dup_done", 32'(done_o[1]), 1);
    check_eq("dup_sc", 32'(sc_o[1]), 16);
    check_eq("dup_pass", 32'(pass_o[1]), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
